// File: rtl/adder_scheduler_pkg.sv
// Shared types and width helpers for the adder scheduler slice.
package adder_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int id_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int lat);
        return ($clog2(lat) < 1) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/adder_scheduler_if.sv
// Request, shared-adder and response signals of the adder scheduler.
interface adder_scheduler_if
    import adder_scheduler_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
);
    localparam int IDW = id_width(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;

    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic                  add_cin;
    logic                  add_busy;
    logic [WIDTH-1:0]      add_sum;
    logic                  add_cout;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic [IDW-1:0]        rsp_id;

    modport slave (
        input  req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
        output req_ready, add_a, add_b, add_cin, add_busy,
               rsp_valid, rsp_sum, rsp_cout, rsp_id
    );

    modport master (
        output req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
        input  req_ready, add_a, add_b, add_cin, add_busy,
               rsp_valid, rsp_sum, rsp_cout, rsp_id
    );

endinterface

// File: rtl/adder_scheduler_arb.sv
// Combinational round-robin picker: first asserted request at or after ptr wins.
module rr_arbiter
    import adder_scheduler_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]               req,
    input  logic [id_width(NREQ)-1:0]     ptr,
    input  logic                          enable,
    output logic [NREQ-1:0]               grant,
    output logic [id_width(NREQ)-1:0]     grant_idx
);
    localparam int IDW = id_width(NREQ);

    logic           found;
    logic [IDW:0]   sum_idx;
    logic [IDW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum_idx   = '0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum_idx = {1'b0, ptr} + (IDW+1)'(i);
            if (sum_idx >= (IDW+1)'(NREQ)) begin
                sum_idx = sum_idx - (IDW+1)'(NREQ);
            end
            idx = sum_idx[IDW-1:0];
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
        if (enable && found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/adder_scheduler.sv
// Round-robin scheduler sharing one multicycle adder; operands stay frozen
// from one accept to the next so the adder can be timed as a multicycle path.
//
// state | meaning
// IDLE  | arbitrating; the winner handshakes and its operands are latched
// WAIT  | adder settling; cnt counts down to terminal 0, then result captured
// RESP  | result held on rsp_* until the consumer takes it
module adder_scheduler
    import adder_scheduler_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int LAT   = 2
) (
    input logic              clk,
    input logic              rst_n,
    adder_scheduler_if.slave bus
);
    localparam int             IDW      = id_width(NREQ);
    localparam int             CW       = cnt_width(LAT);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(LAT - 1);

    state_t           state, state_nxt;
    logic [IDW-1:0]   ptr, ptr_wrap;
    logic [CW-1:0]    cnt;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic             accept, capture;
    logic             busy, rsp_valid;

    logic [WIDTH-1:0] add_a_q, add_b_q, rsp_sum_q;
    logic             add_cin_q, rsp_cout_q;
    logic [IDW-1:0]   rsp_id_q;

    // Gating with rst_n keeps req_ready low for the whole reset window.
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .enable    ((state == IDLE) && rst_n),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign ptr_wrap = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        busy      = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (|grant) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            cnt        <= '0;
            add_a_q    <= '0;
            add_b_q    <= '0;
            add_cin_q  <= 1'b0;
            rsp_id_q   <= '0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
        end else begin
            if (accept) begin
                ptr       <= ptr_wrap;
                cnt       <= CNT_LOAD;
                add_a_q   <= bus.req_a[int'(grant_idx) * WIDTH +: WIDTH];
                add_b_q   <= bus.req_b[int'(grant_idx) * WIDTH +: WIDTH];
                add_cin_q <= bus.req_cin[grant_idx];
                rsp_id_q  <= grant_idx;
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end
            if (capture) begin
                rsp_sum_q  <= bus.add_sum;
                rsp_cout_q <= bus.add_cout;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.add_cin   = add_cin_q;
    assign bus.add_busy  = busy;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.rsp_id    = rsp_id_q;

endmodule

// File: doc/adder_scheduler.md
# adder_scheduler

Shares one combinational prefix-tree adder among NREQ requesters. Each granted operation holds the adder operands stable for LAT cycles, so the tree can be timed as a multicycle path. The block then captures the sum and returns it with the requester ID over a valid/ready response channel. It sits between requesting datapath units and the synthesized adder netlist built from the behavioural cell library.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..16)
- WIDTH, 32, operand width in bits
- LAT, 2, adder multicycle latency in clock cycles (≥1)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  per-requester operation request
- req_ready  output  NREQ  per-requester accept; at most one bit high
- req_a  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  input  NREQ*WIDTH  operand B; same packing as req_a
- req_cin  input  NREQ  carry-in per requester
- add_a  output  WIDTH  registered operand A to the shared adder
- add_b  output  WIDTH  registered operand B to the shared adder
- add_cin  output  1  registered carry-in to the shared adder
- add_busy  output  1  high while the adder result is pending (WAIT state)
- add_sum  input  WIDTH  adder sum (combinational function of add_a/add_b/add_cin)
- add_cout  input  1  adder carry-out
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts the result
- rsp_sum  output  WIDTH  captured sum
- rsp_cout  output  1  captured carry-out
- rsp_id  output  max(1,$clog2(NREQ))  index of the requester that owns the result

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE behaviour:
  - Round-robin search over req_valid, starting at pointer ptr.
  - req_ready[g] is asserted combinationally for the winner g only; it depends on req_valid, and that is permitted.
  - On a handshake: latch req_a/req_b/req_cin of g into add_a/add_b/add_cin, latch g into the ID register, set ptr = (g+1) mod NREQ, load cnt = LAT-1, go to WAIT.
  - With no valid request, stay in IDLE; ptr is unchanged.
- WAIT behaviour:
  - req_ready all zero; add_busy=1.
  - When cnt==0: capture add_sum/add_cout into rsp_sum/rsp_cout, set rsp_valid, go to RESP.
  - Otherwise decrement cnt.
- RESP behaviour:
  - rsp_valid=1; rsp_sum, rsp_cout and rsp_id are held stable.
  - On rsp_valid&&rsp_ready: clear rsp_valid, go to IDLE.
  - There is no accept in RESP; exactly one operation is outstanding at a time.
- add_a/add_b/add_cin are held unchanged from accept until the next accept. The adder inputs never toggle during WAIT or RESP.
- Arithmetic: {rsp_cout, rsp_sum} = add_a + add_b + add_cin, computed entirely by the external adder. The block performs no arithmetic beyond cnt and ptr.
- ptr wraps from NREQ-1 to 0. For non-power-of-two NREQ, ptr never holds an out-of-range value.

## Timing
- Reset (asynchronous, any state): state=IDLE, ptr=0, cnt=0, add_a=0, add_b=0, add_cin=0, add_busy=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, req_ready=0.
- Handshake at rising edge E accepts the operation; the operands appear on add_* after E.
- The result is captured at edge E+LAT; rsp_valid is high after E+LAT.
- Minimum issue interval: LAT+2 cycles (accept, LAT cycles in WAIT, one response cycle, back to IDLE). With rsp_ready held high and continuous requests, accepts occur at E, E+LAT+2, E+2(LAT+2)…
- Reset deasserted mid-operation: the operation is lost, no response is produced, and ptr restarts at 0.
- Request withdrawn: a requester may drop req_valid before its handshake; arbitration uses the current-cycle req_valid only.

## Structure
- Package adder_scheduler_pkg holds:
  - state enum (IDLE, WAIT, RESP)
  - function id_width(n) = max(1,$clog2(n))
  - function cnt_width(lat) = max(1,$clog2(lat))
- Sub-module rr_arbiter, parameterized on NREQ:
  - inputs: req vector, ptr, enable
  - outputs: one-hot grant, binary grant index
  - purely combinational; the scheduler owns ptr.
- Top: FSM, cnt, operand/ID/result registers.

## Test plan
- Single request, LAT=2: requester 1 sends a=0x0000_00FF, b=0x0000_0001, cin=0 → ready at cycle 0; rsp_valid after edge 2; sum=0x0000_0100, cout=0, id=1.
- Carry out: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 → sum=0, cout=1.
- Contention: all 4 requesters held valid, rsp_ready=1 → grant order 0,1,2,3,0; each accept exactly LAT+2 cycles apart; req_ready never has more than one bit set.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_* stable; no req_ready asserted; add_a unchanged; drain on rsp_ready=1, then IDLE.
- Reset mid-WAIT: assert rst_n=0 during cnt=1 → all outputs at their reset values immediately; after release, no response appears and the first grant goes to requester 0.
- Latency sweep: LAT=1 and LAT=4 with requester 3 → response after edge E+1 and E+4 respectively; add_busy high exactly LAT cycles.
